// File: rtl/fpu_mul_man_pipe.sv
// Pipelined mantissa multiplier: normalise and round the W x W product.
// Latency: STAGES enabled cycles from accept to o_valid. Throughput is one operation per cycle.
// Backpressure: a single advance enable freezes every stage while o_valid & ~i_ready, and o_ready follows it.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_valid / o_ready             input handshake
//   i_data_a, i_data_b            mantissas, MSB = hidden bit
//   i_sign, i_rnd_mode, i_tag     sign for the directed modes, rounding mode, sideband tag
//   o_valid / i_ready             output handshake
//   o_data_mul, o_exp_inc         rounded mantissa, exponent increment (0..2)
//   o_inexact, o_zero, o_tag      flags, and the tag of the operation on the output
//   o_busy                        some stage holds a valid operation
module fpu_mul_man_pipe #(
    parameter int SIZE_DATA = 24,
    parameter int STAGES    = 3,
    parameter int TAG_W     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    input  logic                 i_sign,
    input  logic [1:0]           i_rnd_mode,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_data_mul,
    output logic [1:0]           o_exp_inc,
    output logic                 o_inexact,
    output logic                 o_zero,
    output logic [TAG_W-1:0]     o_tag,
    output logic                 o_busy
);

    localparam int W = SIZE_DATA;
    // Number of product/delay register stages that sit ahead of the rounding stage.
    localparam int D = (STAGES > 1) ? STAGES - 1 : 1;

    logic             en;
    logic [2*W-1:0]   prod;
    logic             in_zero;

    // Operands that feed the rounding stage.
    logic [2*W-1:0]   r_p;
    logic             r_sign;
    logic [1:0]       r_mode;
    logic [TAG_W-1:0] r_tag;
    logic             r_zero;
    logic             r_vld;
    logic             pipe_busy;

    // Output registers
    logic             valid_q;
    logic [W-1:0]     data_q;
    logic [1:0]       inc_q;
    logic             inx_q;
    logic             zero_q;
    logic [TAG_W-1:0] tag_q;

    // Rounding stage, combinational part
    logic             norm;
    logic [2*W-1:0]   ps;
    logic [W-1:0]     kept;
    logic             guard;
    logic             sticky;
    logic             rnd_up;
    logic [W:0]       m_sum;
    logic [W-1:0]     data_d;
    logic [1:0]       inc_d;
    logic             inx_d;
    logic             zero_d;

    // The whole pipe moves as one unit. A bubble does not collapse when the output is stalled.
    assign en      = ~valid_q | i_ready;
    assign o_ready = en;

    assign prod    = {{W{1'b0}}, i_data_a} * {{W{1'b0}}, i_data_b};
    assign in_zero = (i_data_a == '0) | (i_data_b == '0);

    generate
        if (STAGES == 1) begin : g_comb
            assign r_p       = prod;
            assign r_sign    = i_sign;
            assign r_mode    = i_rnd_mode;
            assign r_tag     = i_tag;
            assign r_zero    = in_zero;
            assign r_vld     = i_valid;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [2*W-1:0]   p_q    [D];
            logic [1:0]       mode_q [D];
            logic [TAG_W-1:0] tg_q   [D];
            logic [D-1:0]     vld_q;
            logic [D-1:0]     sign_q;
            logic [D-1:0]     zr_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    vld_q <= '0;
                end else if (en) begin
                    vld_q[0] <= i_valid;
                    for (int k = 1; k < D; k++) begin
                        vld_q[k] <= vld_q[k-1];
                    end
                end
            end

            // The payload does not need a reset, because the valid bits qualify it.
            always_ff @(posedge i_clk) begin
                if (en) begin
                    p_q[0]    <= prod;
                    mode_q[0] <= i_rnd_mode;
                    tg_q[0]   <= i_tag;
                    sign_q[0] <= i_sign;
                    zr_q[0]   <= in_zero;
                    for (int k = 1; k < D; k++) begin
                        p_q[k]    <= p_q[k-1];
                        mode_q[k] <= mode_q[k-1];
                        tg_q[k]   <= tg_q[k-1];
                        sign_q[k] <= sign_q[k-1];
                        zr_q[k]   <= zr_q[k-1];
                    end
                end
            end

            assign r_p       = p_q[D-1];
            assign r_sign    = sign_q[D-1];
            assign r_mode    = mode_q[D-1];
            assign r_tag     = tg_q[D-1];
            assign r_zero    = zr_q[D-1];
            assign r_vld     = vld_q[D-1];
            assign pipe_busy = |vld_q;
        end
    endgenerate

    always_comb begin
        norm = r_p[2*W-1];
        // Left-align so that the kept, guard and sticky fields sit at fixed positions.
        ps     = norm ? r_p : (r_p << 1);
        kept   = ps[2*W-1:W];
        guard  = ps[W-1];
        sticky = |ps[W-2:0];
        case (r_mode)
            2'b00:   rnd_up = guard & (sticky | kept[0]);
            2'b01:   rnd_up = 1'b0;
            2'b10:   rnd_up = (guard | sticky) & ~r_sign;
            default: rnd_up = (guard | sticky) & r_sign;
        endcase
        m_sum = {1'b0, kept} + {{W{1'b0}}, rnd_up};
        // A rounding carry means kept was all ones. The result is 1.000... and the exponent goes up by one.
        data_d = m_sum[W] ? {1'b1, {(W-1){1'b0}}} : m_sum[W-1:0];
        inc_d  = {1'b0, norm} + {1'b0, m_sum[W]};
        inx_d  = guard | sticky;
        zero_d = r_zero;
        if (r_zero) begin
            data_d = '0;
            inc_d  = '0;
            inx_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            inc_q   <= '0;
            inx_q   <= 1'b0;
            zero_q  <= 1'b0;
            tag_q   <= '0;
        end else if (en) begin
            valid_q <= r_vld;
            if (r_vld) begin
                data_q <= data_d;
                inc_q  <= inc_d;
                inx_q  <= inx_d;
                zero_q <= zero_d;
                tag_q  <= r_tag;
            end
        end
    end

    assign o_valid    = valid_q;
    assign o_data_mul = data_q;
    assign o_exp_inc  = inc_q;
    assign o_inexact  = inx_q;
    assign o_zero     = zero_q;
    assign o_tag      = tag_q;
    assign o_busy     = pipe_busy | valid_q;

endmodule
